// File: rtl/sd_emu_pkg.sv
// Shared constants for the SD card emulator card-state controller.
// Card states, response types, status bit positions and command indices.
package sd_emu_pkg;

    localparam logic [3:0] CS_IDLE  = 4'd0;
    localparam logic [3:0] CS_READY = 4'd1;
    localparam logic [3:0] CS_IDENT = 4'd2;
    localparam logic [3:0] CS_STBY  = 4'd3;
    localparam logic [3:0] CS_TRAN  = 4'd4;
    localparam logic [3:0] CS_DATA  = 4'd5;

    localparam logic [2:0] RSP_NONE   = 3'd0;
    localparam logic [2:0] RSP_R1     = 3'd1;
    localparam logic [2:0] RSP_R1B    = 3'd2;
    localparam logic [2:0] RSP_R2_CID = 3'd3;
    localparam logic [2:0] RSP_R2_CSD = 3'd4;
    localparam logic [2:0] RSP_R3     = 3'd5;
    localparam logic [2:0] RSP_R6     = 3'd6;
    localparam logic [2:0] RSP_R7     = 3'd7;

    localparam int SB_COM_CRC  = 23;
    localparam int SB_ILLEGAL  = 22;
    localparam int SB_STATE_HI = 12;
    localparam int SB_STATE_LO = 9;
    localparam int SB_READY    = 8;
    localparam int SB_APP_CMD  = 5;

    localparam logic [5:0] CMD0     = 6'd0;
    localparam logic [5:0] CMD2     = 6'd2;
    localparam logic [5:0] CMD3     = 6'd3;
    localparam logic [5:0] ACMD6    = 6'd6;
    localparam logic [5:0] CMD7     = 6'd7;
    localparam logic [5:0] CMD8     = 6'd8;
    localparam logic [5:0] CMD9     = 6'd9;
    localparam logic [5:0] CMD13    = 6'd13;
    localparam logic [5:0] CMD17    = 6'd17;
    localparam logic [5:0] ACMD41   = 6'd41;
    localparam logic [5:0] ACMD42   = 6'd42;
    localparam logic [5:0] CMD55    = 6'd55;
    localparam logic [5:0] IDX_R2R3 = 6'h3F;

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_DECODE,
        ST_RSP,
        ST_RDSTART
    } ctrl_state_t;

    function automatic logic [31:0] r1_status(
        input logic       crc_err,
        input logic       ill_err,
        input logic [3:0] cs,
        input logic       app
    );
        logic [31:0] s;
        s = '0;
        s[SB_COM_CRC] = crc_err;
        s[SB_ILLEGAL] = ill_err;
        s[SB_STATE_HI:SB_STATE_LO] = cs;
        s[SB_READY] = 1'b1;
        s[SB_APP_CMD] = app;
        return s;
    endfunction

endpackage

// File: rtl/sd_emu_cmd_decode.sv
// Combinational command decoder: maps a command in the current card state
// to a response type, the next card state and an illegal-command flag.
module sd_emu_cmd_decode
    import sd_emu_pkg::*;
(
    input  logic [5:0]  i_index,
    input  logic        i_app,
    input  logic [3:0]  i_state,
    input  logic [31:0] i_arg,
    input  logic [15:0] i_rca,
    output logic [2:0]  o_rsp_type,
    output logic [3:0]  o_next_state,
    output logic        o_illegal
);

    logic w_rca_hit;
    logic w_acmd;
    logic w_unused_arg;

    assign w_rca_hit = (i_arg[31:16] == i_rca);
    assign w_acmd = i_app && ((i_index == ACMD6) ||
                              (i_index == ACMD41) ||
                              (i_index == ACMD42));
    assign w_unused_arg = ^{i_arg[15:12], i_arg[7:2]};

    always_comb begin
        o_rsp_type   = RSP_NONE;
        o_next_state = i_state;
        o_illegal    = 1'b1;
        unique case (1'b1)
            (i_index == CMD0): begin
                o_illegal    = 1'b0;
                o_next_state = CS_IDLE;
            end
            (i_index == CMD8): begin
                if (i_state == CS_IDLE) begin
                    o_illegal = 1'b0;
                    if (i_arg[11:8] == 4'h1)
                        o_rsp_type = RSP_R7;
                end
            end
            (i_index == CMD55): begin
                if (i_state != CS_DATA) begin
                    o_illegal  = 1'b0;
                    o_rsp_type = RSP_R1;
                end
            end
            (w_acmd && i_index == ACMD41): begin
                if (i_state == CS_IDLE) begin
                    o_illegal    = 1'b0;
                    o_rsp_type   = RSP_R3;
                    o_next_state = CS_READY;
                end
            end
            (i_index == CMD2): begin
                if (i_state == CS_READY) begin
                    o_illegal    = 1'b0;
                    o_rsp_type   = RSP_R2_CID;
                    o_next_state = CS_IDENT;
                end
            end
            (i_index == CMD3): begin
                if (i_state == CS_IDENT || i_state == CS_STBY) begin
                    o_illegal    = 1'b0;
                    o_rsp_type   = RSP_R6;
                    o_next_state = CS_STBY;
                end
            end
            (i_index == CMD9): begin
                if (i_state == CS_STBY && w_rca_hit) begin
                    o_illegal  = 1'b0;
                    o_rsp_type = RSP_R2_CSD;
                end
            end
            (i_index == CMD7): begin
                if (i_state == CS_STBY && w_rca_hit) begin
                    o_illegal    = 1'b0;
                    o_rsp_type   = RSP_R1B;
                    o_next_state = CS_TRAN;
                end else if (i_state == CS_TRAN && !w_rca_hit) begin
                    o_illegal    = 1'b0;
                    o_next_state = CS_STBY;
                end
            end
            (i_index == CMD13): begin
                if (w_rca_hit &&
                    (i_state == CS_STBY || i_state == CS_TRAN)) begin
                    o_illegal  = 1'b0;
                    o_rsp_type = RSP_R1;
                end
            end
            (w_acmd && i_index == ACMD6): begin
                if (i_state == CS_TRAN && !i_arg[0]) begin
                    o_illegal  = 1'b0;
                    o_rsp_type = RSP_R1;
                end
            end
            (w_acmd && i_index == ACMD42): begin
                if (i_state == CS_TRAN) begin
                    o_illegal  = 1'b0;
                    o_rsp_type = RSP_R1;
                end
            end
            (i_index == CMD17): begin
                if (i_state == CS_TRAN) begin
                    o_illegal    = 1'b0;
                    o_rsp_type   = RSP_R1;
                    o_next_state = CS_DATA;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sd_emu_card_ctrl.sv
// SD card emulator card-state controller: sequences command decode,
// response requests and single-block read starts.
module sd_emu_card_ctrl
    import sd_emu_pkg::*;
#(
    parameter logic [15:0] RCA = 16'h1337,
    parameter logic [31:0] OCR = 32'hC0FF8000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [5:0]  i_cmd_index,
    input  logic [31:0] i_cmd_arg,
    input  logic        i_cmd_crc_ok,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [2:0]  o_rsp_type,
    output logic [5:0]  o_rsp_index,
    output logic [31:0] o_rsp_arg,
    output logic        o_rd_start,
    output logic [31:0] o_rd_addr,
    input  logic        i_rd_done,
    output logic        o_rd_abort,
    output logic        o_bus_4bit,
    output logic [3:0]  o_card_state
);

    ctrl_state_t r_state;
    ctrl_state_t w_nstate;

    logic [5:0]  r_idx;
    logic [31:0] r_arg;
    logic        r_crc_ok;
    logic [3:0]  r_acc_state;
    logic [3:0]  r_card_state;
    logic [3:0]  r_pend_state;
    logic        r_app;
    logic        r_err_crc;
    logic        r_err_ill;
    logic        r_bus_4bit;
    logic        r_is_rd;
    logic        r_rd_abort;
    logic [31:0] r_rd_addr;
    logic [2:0]  r_rsp_type;
    logic [5:0]  r_rsp_index;
    logic [31:0] r_rsp_arg;

    logic        w_cmd_ready;
    logic        w_rsp_valid;
    logic        w_rd_start;
    logic        w_cmd_hs;
    logic        w_rsp_hs;
    logic [2:0]  w_dec_rsp;
    logic [3:0]  w_dec_next;
    logic        w_dec_ill;
    logic        w_good;
    logic        w_has_rsp;
    logic        w_cmd0;
    logic        w_new_app;
    logic [31:0] w_status;
    logic [31:0] w_rsp_arg;
    logic [5:0]  w_rsp_idx;

    sd_emu_cmd_decode u_dec (
        .i_index      (r_idx),
        .i_app        (r_app),
        .i_state      (r_card_state),
        .i_arg        (r_arg),
        .i_rca        (RCA),
        .o_rsp_type   (w_dec_rsp),
        .o_next_state (w_dec_next),
        .o_illegal    (w_dec_ill)
    );

    assign w_cmd_hs  = i_cmd_valid && w_cmd_ready;
    assign w_rsp_hs  = w_rsp_valid && i_rsp_ready;
    assign w_good    = r_crc_ok && !w_dec_ill;
    assign w_has_rsp = w_good && (w_dec_rsp != RSP_NONE);
    assign w_cmd0    = w_good && (r_idx == CMD0);
    assign w_new_app = w_good && (r_idx == CMD55);
    assign w_status  = r1_status(r_err_crc, r_err_ill,
                                 r_acc_state, w_new_app);

    always_comb begin
        w_rsp_arg = '0;
        case (w_dec_rsp)
            RSP_R1, RSP_R1B: w_rsp_arg = w_status;
            RSP_R3:          w_rsp_arg = OCR | 32'hC000_0000;
            RSP_R6:          w_rsp_arg = {RCA,
                                          w_status[SB_COM_CRC],
                                          w_status[SB_ILLEGAL],
                                          w_status[19],
                                          w_status[12:0]};
            RSP_R7:          w_rsp_arg = {20'h0, r_arg[11:0]};
            default:         w_rsp_arg = '0;
        endcase
    end

    assign w_rsp_idx = (w_dec_rsp == RSP_R2_CID ||
                        w_dec_rsp == RSP_R2_CSD ||
                        w_dec_rsp == RSP_R3) ? IDX_R2R3 : r_idx;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            r_state <= ST_WAIT;
        else
            r_state <= w_nstate;
    end

    // Ready also gates on RST_N so it is low for the whole reset window.
    always_comb begin
        w_nstate    = r_state;
        w_cmd_ready = 1'b0;
        w_rsp_valid = 1'b0;
        w_rd_start  = 1'b0;
        unique case (r_state)
            ST_WAIT: begin
                w_cmd_ready = RST_N;
                if (i_cmd_valid && RST_N)
                    w_nstate = ST_DECODE;
            end
            ST_DECODE: begin
                w_nstate = w_has_rsp ? ST_RSP : ST_WAIT;
            end
            ST_RSP: begin
                w_rsp_valid = 1'b1;
                if (i_rsp_ready)
                    w_nstate = r_is_rd ? ST_RDSTART : ST_WAIT;
            end
            ST_RDSTART: begin
                w_rd_start = 1'b1;
                w_nstate   = ST_WAIT;
            end
            default: w_nstate = ST_WAIT;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_idx        <= '0;
            r_arg        <= '0;
            r_crc_ok     <= 1'b0;
            r_acc_state  <= CS_IDLE;
            r_card_state <= CS_IDLE;
            r_pend_state <= CS_IDLE;
            r_app        <= 1'b0;
            r_err_crc    <= 1'b0;
            r_err_ill    <= 1'b0;
            r_bus_4bit   <= 1'b0;
            r_is_rd      <= 1'b0;
            r_rd_abort   <= 1'b0;
            r_rd_addr    <= '0;
            r_rsp_type   <= RSP_NONE;
            r_rsp_index  <= '0;
            r_rsp_arg    <= '0;
        end else begin
            r_rd_abort <= 1'b0;
            if (w_cmd_hs) begin
                r_idx       <= i_cmd_index;
                r_arg       <= i_cmd_arg;
                r_crc_ok    <= i_cmd_crc_ok;
                r_acc_state <= r_card_state;
            end
            if (r_card_state == CS_DATA && i_rd_done)
                r_card_state <= CS_TRAN;
            if (r_state == ST_DECODE) begin
                r_app        <= w_new_app;
                r_rsp_type   <= w_has_rsp ? w_dec_rsp : RSP_NONE;
                r_rsp_index  <= w_rsp_idx;
                r_rsp_arg    <= w_rsp_arg;
                r_pend_state <= w_dec_next;
                r_is_rd      <= w_has_rsp && (r_idx == CMD17);
                if (!r_crc_ok)
                    r_err_crc <= 1'b1;
                else if (w_dec_ill)
                    r_err_ill <= 1'b1;
                if (w_good && w_dec_rsp == RSP_NONE)
                    r_card_state <= w_dec_next;
                if (w_has_rsp && r_idx == ACMD6)
                    r_bus_4bit <= r_arg[1];
                if (w_has_rsp && r_idx == CMD17)
                    r_rd_addr <= r_arg;
                // A coincident rd_done means the block already finished.
                if (w_cmd0) begin
                    r_bus_4bit <= 1'b0;
                    r_err_crc  <= 1'b0;
                    r_err_ill  <= 1'b0;
                    r_app      <= 1'b0;
                    r_rd_abort <= (r_card_state == CS_DATA) && !i_rd_done;
                end
            end
            if (w_rsp_hs) begin
                r_card_state <= r_pend_state;
                if (r_rsp_type == RSP_R1 || r_rsp_type == RSP_R1B ||
                    r_rsp_type == RSP_R6) begin
                    r_err_crc <= 1'b0;
                    r_err_ill <= 1'b0;
                end
            end
        end
    end

    assign o_cmd_ready  = w_cmd_ready;
    assign o_rsp_valid  = w_rsp_valid;
    assign o_rsp_type   = r_rsp_type;
    assign o_rsp_index  = r_rsp_index;
    assign o_rsp_arg    = r_rsp_arg;
    assign o_rd_start   = w_rd_start;
    assign o_rd_addr    = r_rd_addr;
    assign o_rd_abort   = r_rd_abort;
    assign o_bus_4bit   = r_bus_4bit;
    assign o_card_state = r_card_state;

endmodule

// File: doc/sd_emu_card_ctrl.md
# sd_emu_card_ctrl

Card-state controller for the SD card emulator. It sits between the command receiver, which delivers CRC-checked 48-bit host commands, and two blocks: the response transmitter and the data-block transmitter. It tracks the SD card state (idle, ready, ident, stby, tran, data) and decides, per command, which response to send and with what argument. It also starts single-block reads and owns the negotiated bus width.

## Interface
Parameters:
- RCA, 16'h1337, relative card address published by CMD3.
- OCR, 32'hC0FF8000, OCR returned in R3; bit 31 (busy done) and bit 30 (CCS) are always forced to 1.

Ports:
- CLK  in  1  single system clock.
- RST_N  in  1  reset, asynchronous, active-low.
- i_cmd_valid  in  1  command available from receiver.
- o_cmd_ready  out  1  controller accepts command.
- i_cmd_index  in  6  command index.
- i_cmd_arg  in  32  command argument.
- i_cmd_crc_ok  in  1  CRC7 of received command was good.
- o_rsp_valid  out  1  response request to transmitter.
- i_rsp_ready  in  1  transmitter took the response.
- o_rsp_type  out  3  response type: NONE=0, R1=1, R1B=2, R2_CID=3, R2_CSD=4, R3=5, R6=6, R7=7.
- o_rsp_index  out  6  index field to transmit: the command index, or 6'h3F for R2/R3.
- o_rsp_arg  out  32  32-bit response payload; unused for R2.
- o_rd_start  out  1  one-cycle pulse to start a block read.
- o_rd_addr  out  32  block address, latched from the CMD17 argument.
- i_rd_done  in  1  data transmitter finished the block, including CRC16 and end bit.
- o_rd_abort  out  1  one-cycle pulse that aborts an in-flight block.
- o_bus_4bit  out  1  1 = 4-bit data bus, 0 = 1-bit.
- o_card_state  out  4  current card state, for debug and LEDs.

## Operation
- Card states use SD CURRENT_STATE encoding: IDLE=0, READY=1, IDENT=2, STBY=3, TRAN=4, DATA=5.
- The controller FSM has four states: WAIT, DECODE, RSP, RDSTART.
- **WAIT:** o_cmd_ready=1. A handshake latches index, arg and crc_ok, then moves to DECODE.
- **DECODE (one cycle):**
  - Computes the response and the next card state.
  - If a response is due, goes to RSP.
  - If not, applies the state change and returns to WAIT.
- **RSP:** holds o_rsp_valid and the response fields until i_rsp_ready. On the handshake:
  - applies the pending card-state change;
  - goes to RDSTART if the command was CMD17, otherwise to WAIT.
- **RDSTART:** pulses o_rd_start with card state DATA, then goes to WAIT.
- Bad CRC: no response, COM_CRC_ERROR (bit 23) is set, and the card state is unchanged.
- App-command flag: set by an accepted CMD55 and cleared by the next accepted command of any kind. When the flag is set, index 6/41/42 is decoded as ACMD.
- Command table. Any entry not listed, including a listed command in a wrong state, is ILLEGAL: no response and bit 22 is set.
  - CMD0, any state: no response. Card state becomes IDLE, bus width becomes 1-bit, and all flags clear. If the card is in DATA, o_rd_abort also pulses.
  - CMD8 in IDLE: R7 with {20'h0, arg[11:0]} when arg[11:8]==1. Otherwise no response and no error.
  - CMD55 in any state except DATA: R1.
  - ACMD41 in IDLE: R3 with arg=OCR|32'hC000_0000. Card state becomes READY.
  - CMD2 in READY: R2_CID. Card state becomes IDENT.
  - CMD3 in IDENT or STBY: R6 with arg {RCA, status[23:22], status[19], status[12:0]}. Card state becomes STBY.
  - CMD9 in STBY with arg[31:16]==RCA: R2_CSD.
  - CMD7:
    - In STBY with matching RCA: R1B, card state becomes TRAN.
    - In TRAN with a non-matching RCA: no response, card state becomes STBY.
  - CMD13 with matching RCA, in STBY or TRAN: R1.
  - ACMD6 in TRAN:
    - arg[1:0]=00 sets 1-bit, =10 sets 4-bit, then R1.
    - Other values are ILLEGAL.
  - ACMD42 in TRAN: R1; the argument is ignored.
  - CMD17 in TRAN: R1, o_rd_addr=arg, then RDSTART.
- R1 status word contents:
  - bits 23 and 22: the sticky error flags;
  - bits 12:9: the card state at command acceptance;
  - bit 8: READY_FOR_DATA, always 1;
  - bit 5: APP_CMD, which is the flag value after this command.
- Bits 23 and 22 clear once they have been reported in an R1 or R6.
- In DATA, i_rd_done returns the card state to TRAN.

## Timing
- Reset values:
  - o_cmd_ready=0 during reset and 1 in the first cycle after RST_N rises;
  - all other outputs 0, with o_rsp_type=NONE and o_card_state=IDLE.
- o_rsp_valid rises exactly two cycles after the command handshake.
- o_rd_start pulses in the cycle after the response handshake.
- The state change from i_rd_done applies in the same cycle it is sampled. If i_rd_done and a CMD0 decode coincide, CMD0 wins: the final state is IDLE and o_rd_abort does not pulse.
- o_cmd_ready stays low from DECODE through RDSTART, so commands never overlap.
- RST_N asserted mid-response: o_rsp_valid drops asynchronously and no o_rd_start is issued.

## Structure
- Package sd_emu_pkg holds:
  - card-state and response-type localparams;
  - status bit positions (23, 22, 12:9, 8, 5);
  - CMD/ACMD index constants.
- One natural sub-module, sd_emu_cmd_decode: purely combinational decoding of (index, app flag, card state, arg, RCA) into (rsp type, next state, illegal).

## Test plan
- CMD0 sequence: CMD0, CMD8 arg 0x1AA, CMD55, ACMD41, CMD2, CMD3, CMD9 arg 0x13370000, CMD7 arg 0x13370000.
  - Responses: none, R7 0x000001AA, R1 with bit5=1, R3 0xC0FF8000, R2_CID, R6 0x13370500, R2_CSD, R1B.
  - Card state ends at TRAN.
- CMD55 + ACMD6 arg 2 in TRAN → R1 and o_bus_4bit=1. ACMD6 arg 3 → no response; the next CMD13 R1 has bit22=1, and the R1 after that has bit22=0.
- CMD17 arg 0x40 in TRAN → R1, then o_rd_start pulses with o_rd_addr=0x40 and state is DATA. i_rd_done → state TRAN.
- CMD0 while in DATA → o_rd_abort pulses and state becomes IDLE with o_bus_4bit=0. Also drive i_rd_done in the same cycle → still IDLE, no abort.
- i_cmd_crc_ok=0 on CMD55 → no response; the next R1 has bit23=1 and bit5 reflecting that command only.
- Hold i_rsp_ready low for 50 cycles → o_rsp_valid and the response fields stay stable and o_cmd_ready stays 0. Assert RST_N mid-wait → all outputs reset.
